// File: rtl/ysyx_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_lsu
//  Purpose  : Multi-cycle load/store unit between execute stage and a
//             valid/ready data-memory bus. Builds byte-lane masks, aligns
//             store data, extends load data and reports misaligned,
//             bus-error and timeout conditions.
//  Revision : 1.0  initial release
// ============================================================================
module ysyx_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_is_store,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    input  logic [XLEN-1:0]     in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    output logic                out_valid,
    output logic [XLEN-1:0]     out_rdata,
    output logic [1:0]          out_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [XLEN-1:0]     mem_req_addr,
    output logic                mem_req_wen,
    output logic [XLEN-1:0]     mem_req_wdata,
    output logic [XLEN/8-1:0]   mem_req_wmask,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rsp_rdata,
    input  logic                mem_rsp_err
);

    localparam int c_nb  = XLEN / 8;
    localparam int c_ofs = $clog2(c_nb);
    localparam int c_cw  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_cw-1:0] c_to = c_cw'(TIMEOUT);

    localparam logic [1:0] c_err_ok    = 2'b00;
    localparam logic [1:0] c_err_align = 2'b01;
    localparam logic [1:0] c_err_bus   = 2'b10;
    localparam logic [1:0] c_err_tmo   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_store;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [c_ofs-1:0]   r_off;
    logic [c_cw-1:0]    r_cnt;

    logic [c_ofs-1:0]   w_in_off;
    logic [c_ofs-1:0]   w_align_mask;
    logic [c_nb-1:0]    w_bytes_mask;
    logic [c_nb-1:0]    w_wmask;
    logic [XLEN-1:0]    w_wdata;
    logic               w_misalign;
    logic               w_illegal;
    logic [XLEN-1:0]    w_shift;
    logic [XLEN-1:0]    w_load;
    logic [c_cw-1:0]    w_cnt_next;
    logic               w_timeout;

    assign in_ready = (r_state == S_IDLE) && !rst;

    assign w_in_off   = in_addr[c_ofs-1:0];
    assign w_misalign = |(w_in_off & w_align_mask);
    // A double-word access has no meaning on a 32-bit datapath.
    assign w_illegal  = (in_size == 2'b11) && (XLEN < 64);
    assign w_wmask    = w_bytes_mask << w_in_off;
    assign w_wdata    = in_wdata << {w_in_off, 3'b000};

    assign w_shift    = mem_rsp_rdata >> {r_off, 3'b000};
    assign w_cnt_next = r_cnt + c_cw'(1);
    assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == c_to);

    // Per-size offset alignment mask and byte-lane pattern before shifting.
    always_comb begin
        w_align_mask = '0;
        w_bytes_mask = c_nb'(1);
        case (in_size)
            2'b00: begin w_align_mask = c_ofs'(0); w_bytes_mask = c_nb'(1);   end
            2'b01: begin w_align_mask = c_ofs'(1); w_bytes_mask = c_nb'(3);   end
            2'b10: begin w_align_mask = c_ofs'(3); w_bytes_mask = c_nb'(15);  end
            default: begin w_align_mask = c_ofs'(7); w_bytes_mask = c_nb'(255); end
        endcase
    end

    // Truncate the lane-shifted read word to the access size and extend it.
    always_comb begin
        w_load = '0;
        case (r_size)
            2'b00:   w_load = r_uns ? XLEN'(w_shift[7:0])  : XLEN'($signed(w_shift[7:0]));
            2'b01:   w_load = r_uns ? XLEN'(w_shift[15:0]) : XLEN'($signed(w_shift[15:0]));
            2'b10:   w_load = r_uns ? XLEN'(w_shift[31:0]) : XLEN'($signed(w_shift[31:0]));
            default: w_load = w_shift;
        endcase
    end

    // Main sequencer: accept, bus request, response capture, completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_store       <= 1'b0;
            r_size        <= 2'b00;
            r_uns         <= 1'b0;
            r_off         <= '0;
            r_cnt         <= '0;
            out_valid     <= 1'b0;
            out_rdata     <= '0;
            out_err       <= c_err_ok;
            mem_req_valid <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wen   <= 1'b0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else begin
            out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_store <= in_is_store;
                        r_size  <= in_size;
                        r_uns   <= in_unsigned;
                        r_off   <= w_in_off;
                        r_cnt   <= '0;
                        if (w_misalign || w_illegal) begin
                            r_state   <= S_DONE;
                            out_valid <= 1'b1;
                            out_rdata <= '0;
                            out_err   <= c_err_align;
                        end else begin
                            r_state       <= S_REQ;
                            mem_req_valid <= 1'b1;
                            mem_req_addr  <= {in_addr[XLEN-1:c_ofs], {c_ofs{1'b0}}};
                            mem_req_wen   <= in_is_store;
                            mem_req_wdata <= w_wdata;
                            mem_req_wmask <= in_is_store ? w_wmask : '0;
                        end
                    end
                end
                S_REQ: begin
                    if (TIMEOUT != 0) r_cnt <= w_cnt_next;
                    if (w_timeout) begin
                        r_state       <= S_DONE;
                        mem_req_valid <= 1'b0;
                        out_valid     <= 1'b1;
                        out_rdata     <= '0;
                        out_err       <= c_err_tmo;
                    end else if (mem_req_ready) begin
                        r_state       <= S_RSP;
                        mem_req_valid <= 1'b0;
                    end
                end
                S_RSP: begin
                    if (TIMEOUT != 0) r_cnt <= w_cnt_next;
                    // A response arriving on the final allowed cycle still counts.
                    if (mem_rsp_valid) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        out_rdata <= (r_store || mem_rsp_err) ? '0 : w_load;
                        out_err   <= mem_rsp_err ? c_err_bus : c_err_ok;
                    end else if (w_timeout) begin
                        r_state   <= S_DONE;
                        out_valid <= 1'b1;
                        out_rdata <= '0;
                        out_err   <= c_err_tmo;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_lsu
//  Purpose  : Directed self-checking bench for ysyx_lsu (32-bit instance with
//             a short timeout, plus a 64-bit instance for wide accesses).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ysyx_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 32-bit instance
    logic        a_in_valid, a_in_ready, a_in_is_store, a_in_unsigned;
    logic [1:0]  a_in_size;
    logic [31:0] a_in_addr, a_in_wdata;
    logic        a_out_valid;
    logic [31:0] a_out_rdata;
    logic [1:0]  a_out_err;
    logic        a_mem_req_valid, a_mem_req_ready, a_mem_req_wen;
    logic [31:0] a_mem_req_addr, a_mem_req_wdata;
    logic [3:0]  a_mem_req_wmask;
    logic        a_mem_rsp_valid, a_mem_rsp_err;
    logic [31:0] a_mem_rsp_rdata;

    // 64-bit instance
    logic        b_in_valid, b_in_ready, b_in_is_store, b_in_unsigned;
    logic [1:0]  b_in_size;
    logic [63:0] b_in_addr, b_in_wdata;
    logic        b_out_valid;
    logic [63:0] b_out_rdata;
    logic [1:0]  b_out_err;
    logic        b_mem_req_valid, b_mem_req_ready, b_mem_req_wen;
    logic [63:0] b_mem_req_addr, b_mem_req_wdata;
    logic [7:0]  b_mem_req_wmask;
    logic        b_mem_rsp_valid, b_mem_rsp_err;
    logic [63:0] b_mem_rsp_rdata;

    int n_vec = 0;
    int n_err = 0;

    ysyx_lsu #(.XLEN(32), .TIMEOUT(8)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_is_store(a_in_is_store),
        .in_size(a_in_size), .in_unsigned(a_in_unsigned), .in_addr(a_in_addr),
        .in_wdata(a_in_wdata), .out_valid(a_out_valid), .out_rdata(a_out_rdata),
        .out_err(a_out_err), .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
        .mem_req_addr(a_mem_req_addr), .mem_req_wen(a_mem_req_wen),
        .mem_req_wdata(a_mem_req_wdata), .mem_req_wmask(a_mem_req_wmask),
        .mem_rsp_valid(a_mem_rsp_valid), .mem_rsp_rdata(a_mem_rsp_rdata),
        .mem_rsp_err(a_mem_rsp_err)
    );

    ysyx_lsu #(.XLEN(64), .TIMEOUT(255)) u_dut64 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_is_store(b_in_is_store),
        .in_size(b_in_size), .in_unsigned(b_in_unsigned), .in_addr(b_in_addr),
        .in_wdata(b_in_wdata), .out_valid(b_out_valid), .out_rdata(b_out_rdata),
        .out_err(b_out_err), .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
        .mem_req_addr(b_mem_req_addr), .mem_req_wen(b_mem_req_wen),
        .mem_req_wdata(b_mem_req_wdata), .mem_req_wmask(b_mem_req_wmask),
        .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_rdata(b_mem_rsp_rdata),
        .mem_rsp_err(b_mem_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single cycle, then scramble the inputs.
    task automatic a_issue(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] ad, input logic [31:0] wd);
        a_in_valid = 1'b1; a_in_is_store = st; a_in_size = sz;
        a_in_unsigned = un; a_in_addr = ad; a_in_wdata = wd;
        tick;
        a_in_valid = 1'b0; a_in_addr = 32'hDEAD_0000; a_in_wdata = 32'h5A5A_5A5A;
        a_in_size = 2'b00; a_in_is_store = 1'b0; a_in_unsigned = 1'b0;
    endtask

    task automatic b_issue(input logic st, input logic [1:0] sz, input logic un,
                           input logic [63:0] ad, input logic [63:0] wd);
        b_in_valid = 1'b1; b_in_is_store = st; b_in_size = sz;
        b_in_unsigned = un; b_in_addr = ad; b_in_wdata = wd;
        tick;
        b_in_valid = 1'b0; b_in_addr = 64'hDEAD_0000_0000_0000; b_in_wdata = '0;
    endtask

    initial begin
        a_in_valid = 0; a_in_is_store = 0; a_in_unsigned = 0; a_in_size = 0;
        a_in_addr = 0; a_in_wdata = 0; a_mem_req_ready = 0;
        a_mem_rsp_valid = 0; a_mem_rsp_err = 0; a_mem_rsp_rdata = 0;
        b_in_valid = 0; b_in_is_store = 0; b_in_unsigned = 0; b_in_size = 0;
        b_in_addr = 0; b_in_wdata = 0; b_mem_req_ready = 0;
        b_mem_rsp_valid = 0; b_mem_rsp_err = 0; b_mem_rsp_rdata = 0;

        // Reset state
        rst = 1'b1;
        tick; tick;
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_req_valid", a_mem_req_valid, 0);
        chk("rst_out_rdata", a_out_rdata, 0);
        chk("rst_out_err",   a_out_err, 0);
        chk("rst_wmask",     a_mem_req_wmask, 0);
        chk("rst_in_ready",  a_in_ready, 0);
        rst = 1'b0;
        #1;
        chk("idle_in_ready", a_in_ready, 1);

        // 1: signed byte load at offset 3, minimum latency
        a_mem_req_ready = 1'b1;
        a_issue(1'b0, 2'b00, 1'b0, 32'h8000_0003, 32'h0);        // N+1
        chk("t1_req_valid", a_mem_req_valid, 1);
        chk("t1_req_addr",  a_mem_req_addr, 32'h8000_0000);
        chk("t1_wmask",     a_mem_req_wmask, 4'b0000);
        chk("t1_wen",       a_mem_req_wen, 0);
        chk("t1_in_ready",  a_in_ready, 0);
        tick;                                                     // N+2
        chk("t1_req_drop",  a_mem_req_valid, 0);
        chk("t1_no_early",  a_out_valid, 0);
        a_mem_rsp_valid = 1'b1; a_mem_rsp_rdata = 32'h8000_0000;
        tick;                                                     // N+3
        a_mem_rsp_valid = 1'b0;
        chk("t1_out_valid", a_out_valid, 1);
        chk("t1_out_rdata", a_out_rdata, 32'hFFFF_FF80);
        chk("t1_out_err",   a_out_err, 2'b00);
        tick;                                                     // N+4
        chk("t1_ready_back", a_in_ready, 1);
        chk("t1_pulse_end",  a_out_valid, 0);
        chk("t1_rdata_hold", a_out_rdata, 32'hFFFF_FF80);

        // 2: store half at 0x102 with a stalled bus
        a_mem_req_ready = 1'b0;
        a_issue(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h0000_BEEF);
        chk("t2_req_valid", a_mem_req_valid, 1);
        chk("t2_req_addr",  a_mem_req_addr, 32'h0000_0100);
        chk("t2_wdata",     a_mem_req_wdata, 32'hBEEF_0000);
        chk("t2_wmask",     a_mem_req_wmask, 4'b1100);
        chk("t2_wen",       a_mem_req_wen, 1);
        tick;
        chk("t2_hold_valid", a_mem_req_valid, 1);
        chk("t2_hold_wdata", a_mem_req_wdata, 32'hBEEF_0000);
        chk("t2_hold_addr",  a_mem_req_addr, 32'h0000_0100);
        a_mem_req_ready = 1'b1;
        tick;
        chk("t2_req_drop",  a_mem_req_valid, 0);
        a_mem_rsp_valid = 1'b1; a_mem_rsp_rdata = 32'h1234_5678;
        tick;
        a_mem_rsp_valid = 1'b0;
        chk("t2_out_valid", a_out_valid, 1);
        chk("t2_out_rdata", a_out_rdata, 32'h0);
        chk("t2_out_err",   a_out_err, 2'b00);
        tick;

        // 3: misaligned word and illegal double
        a_issue(1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
        chk("t3_no_req",    a_mem_req_valid, 0);
        chk("t3_out_valid", a_out_valid, 1);
        chk("t3_out_err",   a_out_err, 2'b01);
        chk("t3_out_rdata", a_out_rdata, 32'h0);
        tick;
        a_issue(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'h0);
        chk("t3b_no_req",    a_mem_req_valid, 0);
        chk("t3b_out_valid", a_out_valid, 1);
        chk("t3b_out_err",   a_out_err, 2'b01);
        tick;

        // 4: timeout with TIMEOUT=8
        a_mem_req_ready = 1'b0;
        a_issue(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);         // N+1
        for (int k = 1; k <= 7; k++) tick;                        // N+8
        chk("t4_pre_valid", a_out_valid, 0);
        chk("t4_pre_req",   a_mem_req_valid, 1);
        tick;                                                     // N+9
        chk("t4_out_valid", a_out_valid, 1);
        chk("t4_out_err",   a_out_err, 2'b11);
        chk("t4_req_drop",  a_mem_req_valid, 0);
        chk("t4_out_rdata", a_out_rdata, 32'h0);
        tick;
        a_mem_rsp_valid = 1'b1; a_mem_rsp_rdata = 32'h5555_5555;
        tick;
        a_mem_rsp_valid = 1'b0;
        chk("t4_stray_ign", a_out_valid, 0);
        chk("t4_ready",     a_in_ready, 1);
        a_mem_req_ready = 1'b1;
        a_issue(1'b0, 2'b10, 1'b1, 32'h0000_0204, 32'h0);
        tick;
        a_mem_rsp_valid = 1'b1; a_mem_rsp_rdata = 32'hCAFE_BABE;
        tick;
        a_mem_rsp_valid = 1'b0;
        chk("t4_next_valid", a_out_valid, 1);
        chk("t4_next_rdata", a_out_rdata, 32'hCAFE_BABE);
        chk("t4_next_err",   a_out_err, 2'b00);
        tick;

        // 5a: unsigned half load with bus error
        a_issue(1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'h0);
        tick;
        a_mem_rsp_valid = 1'b1; a_mem_rsp_err = 1'b1; a_mem_rsp_rdata = 32'hFFFF_FFFF;
        tick;
        a_mem_rsp_valid = 1'b0; a_mem_rsp_err = 1'b0;
        chk("t5_out_valid", a_out_valid, 1);
        chk("t5_out_err",   a_out_err, 2'b10);
        chk("t5_out_rdata", a_out_rdata, 32'h0);
        tick;

        // 5b: 64-bit word loads from the upper half, then a double store
        b_mem_req_ready = 1'b1;
        b_issue(1'b0, 2'b10, 1'b1, 64'h4, 64'h0);
        chk("t5b_req_addr", b_mem_req_addr, 64'h0);
        chk("t5b_wmask",    b_mem_req_wmask, 8'h00);
        tick;
        b_mem_rsp_valid = 1'b1; b_mem_rsp_rdata = 64'h8765_4321_0000_0000;
        tick;
        b_mem_rsp_valid = 1'b0;
        chk("t5b_out_valid", b_out_valid, 1);
        chk("t5b_uns_rdata", b_out_rdata, 64'h0000_0000_8765_4321);
        tick;
        b_issue(1'b0, 2'b10, 1'b0, 64'h4, 64'h0);
        tick;
        b_mem_rsp_valid = 1'b1;
        tick;
        b_mem_rsp_valid = 1'b0;
        chk("t5b_sgn_rdata", b_out_rdata, 64'hFFFF_FFFF_8765_4321);
        tick;
        b_issue(1'b1, 2'b11, 1'b0, 64'h8, 64'h1122_3344_5566_7788);
        chk("t5b_dw_wmask", b_mem_req_wmask, 8'hFF);
        chk("t5b_dw_wdata", b_mem_req_wdata, 64'h1122_3344_5566_7788);
        chk("t5b_dw_addr",  b_mem_req_addr, 64'h8);
        tick;
        b_mem_rsp_valid = 1'b1;
        tick;
        b_mem_rsp_valid = 1'b0;
        chk("t5b_dw_err",   b_out_err, 2'b00);
        chk("t5b_dw_rdata", b_out_rdata, 64'h0);
        tick;

        // 6: reset while waiting for a response
        a_issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);         // N+1
        tick;                                                     // N+2, RSP
        chk("t6_in_rsp", a_mem_req_valid, 0);
        rst = 1'b1;
        tick;
        chk("t6_rst_req",   a_mem_req_valid, 0);
        chk("t6_rst_valid", a_out_valid, 0);
        chk("t6_rst_ready", a_in_ready, 0);
        rst = 1'b0;
        a_mem_rsp_valid = 1'b1; a_mem_rsp_rdata = 32'h0000_0001;
        #1;
        chk("t6_ready_after", a_in_ready, 1);
        tick;
        a_mem_rsp_valid = 1'b0;
        chk("t6_no_valid", a_out_valid, 0);
        chk("t6_no_req",   a_mem_req_valid, 0);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
